// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch queue.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FLUSH = 2'd2
  } fetch_state_t;

  localparam int MAX_INSN_LEN = 6;
  localparam int WINDOW_BYTES = 4;

  // Lengths outside 1..MAX_INSN_LEN are never retired.
  function automatic logic len_ok(input logic [3:0] len);
    return (len != 4'd0) && (len <= 4'(MAX_INSN_LEN));
  endfunction

endpackage

// File: rtl/ifq_ring.sv
// Byte ring for the fetch queue: one write port, WINDOW_BYTES combinational
// read ports at consecutive offsets from rd_ptr (wrapping mod QDEPTH).
module ifq_ring
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 8,
  parameter int PW     = $clog2(QDEPTH)
) (
  input  logic                      clk2,
  input  logic                      we,
  input  logic [PW-1:0]             wr_ptr,
  input  logic [7:0]                wr_data,
  input  logic [PW-1:0]             rd_ptr,
  output logic [WINDOW_BYTES*8-1:0] rd_data
);

  logic [7:0] mem [QDEPTH];

  always_ff @(posedge clk2) begin
    if (we) mem[wr_ptr] <= wr_data;
  end

  for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_rd
    logic [PW-1:0] addr;
    assign addr = rd_ptr + PW'(gi);
    assign rd_data[8*gi +: 8] = mem[addr];
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: byte-wise code fetch into a ring, 32-bit window at eip.
// Optional stall counter output enabled by defining IFETCH_STALL_CNT_EN.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int          QDEPTH    = 8,
  parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
  input  logic        clk2,
  input  logic        reset_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [31:0] ope,
  output logic        ope_valid,
  output logic [31:0] eip,
  input  logic        consume,
  input  logic [3:0]  consume_len,
  output logic        consume_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_addr
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fetch_state_t   state_reg;
  logic [CW-1:0]  count_reg;
  logic [PW-1:0]  rd_ptr_reg;
  logic [PW-1:0]  wr_ptr_reg;
  logic [31:0]    eip_reg;
  logic [31:0]    fetch_addr_reg;

  logic           fill;
  logic           take;
  logic [CW-1:0]  take_len;
  logic [CW-1:0]  count_next;
  logic [WINDOW_BYTES*8-1:0] ring_data;

  assign mem_req  = (state_reg == S_FETCH) && (count_reg < CW'(QDEPTH)) && !redirect;
  assign mem_addr = fetch_addr_reg;

  // An ack without an outstanding request is ignored.
  assign fill          = mem_req && mem_ack;
  assign consume_ready = 8'(count_reg) >= 8'(consume_len);
  assign take          = consume && consume_ready && len_ok(consume_len);
  assign take_len      = take ? CW'(consume_len) : '0;
  assign count_next    = count_reg - take_len + CW'(fill);

  assign eip       = eip_reg;
  assign ope_valid = count_reg >= CW'(WINDOW_BYTES);

  ifq_ring #(
    .QDEPTH (QDEPTH),
    .PW     (PW)
  ) u_ring (
    .clk2    (clk2),
    .we      (fill),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (mem_data),
    .rd_ptr  (rd_ptr_reg),
    .rd_data (ring_data)
  );

  // Byte gi of the window sits at eip+gi; bytes not yet fetched read as zero.
  for (genvar gi = 0; gi < WINDOW_BYTES; gi++) begin : g_win
    assign ope[31-8*gi -: 8] = (8'(count_reg) > 8'(gi)) ? ring_data[8*gi +: 8] : 8'h00;
  end

  always_ff @(posedge clk2) begin
    if (!reset_n) begin
      state_reg      <= S_IDLE;
      count_reg      <= '0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      eip_reg        <= RESET_EIP;
      fetch_addr_reg <= RESET_EIP;
    end else begin
      case (state_reg)
        S_IDLE:  state_reg <= S_FETCH;
        S_FETCH: if (redirect) state_reg <= S_FLUSH;
        S_FLUSH: state_reg <= S_FETCH;
        default: state_reg <= S_IDLE;
      endcase

      // Redirect wins over any fill or consume in the same cycle.
      if (redirect) begin
        count_reg      <= '0;
        rd_ptr_reg     <= '0;
        wr_ptr_reg     <= '0;
        eip_reg        <= redirect_addr;
        fetch_addr_reg <= redirect_addr;
      end else begin
        count_reg <= count_next;
        if (fill) begin
          wr_ptr_reg     <= wr_ptr_reg + PW'(1);
          fetch_addr_reg <= fetch_addr_reg + 32'd1;
        end
        if (take) begin
          rd_ptr_reg <= rd_ptr_reg + PW'(take_len);
          eip_reg    <= eip_reg + 32'(take_len);
        end
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk2) begin
    if (!reset_n) begin
      stall_cnt_reg <= 16'd0;
    end else if (consume && !consume_ready && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a byte-queue reference model.
module tb_ifetch_queue;

  localparam int          QDEPTH    = 8;
  localparam logic [31:0] RESET_EIP = 32'h0000_0000;

  logic        clk2 = 1'b0;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [31:0] ope;
  logic        ope_valid;
  logic [31:0] eip;
  logic        consume;
  logic [3:0]  consume_len;
  logic        consume_ready;
  logic        redirect;
  logic [31:0] redirect_addr;
`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk2 = ~clk2;

  ifetch_queue #(
    .QDEPTH    (QDEPTH),
    .RESET_EIP (RESET_EIP)
  ) dut (
    .clk2          (clk2),
    .reset_n       (reset_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .ope           (ope),
    .ope_valid     (ope_valid),
    .eip           (eip),
    .consume       (consume),
    .consume_len   (consume_len),
    .consume_ready (consume_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the queued code bytes in address order starting at m_eip.
  logic [7:0]  q[$];
  logic [31:0] m_eip   = RESET_EIP;
  int          m_block = 1;     // cycles during which no request may be issued
  logic [15:0] m_stall = 16'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] code_byte(input logic [31:0] a);
    return a[7:0] ^ a[23:16];
  endfunction

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic rn, input logic ack, input logic cons,
                       input logic [3:0] len, input logic redir, input logic [31:0] raddr);
    logic [31:0] fa;
    logic [31:0] exp_ope;
    logic        req_e;
    logic        rdy_e;
    logic        take;
    int          sz;
    sz            = q.size();
    fa            = m_eip + 32'(sz);
    reset_n       = rn;
    mem_ack       = ack;
    consume       = cons;
    consume_len   = len;
    redirect      = redir;
    redirect_addr = raddr;
    mem_data      = code_byte(fa);
    #1;
    req_e = (m_block == 0) && (sz < QDEPTH) && !redir;
    rdy_e = sz >= int'(len);
    exp_ope = 32'd0;
    for (int k = 0; k < 4; k++) exp_ope = {exp_ope[23:0], (k < sz) ? q[k] : 8'h00};
    check("mem_req", {31'd0, mem_req}, {31'd0, req_e});
    check("mem_addr", mem_addr, fa);
    check("ope", ope, exp_ope);
    check("ope_valid", {31'd0, ope_valid}, {31'd0, sz >= 4});
    check("eip", eip, m_eip);
    check("consume_ready", {31'd0, consume_ready}, {31'd0, rdy_e});
`ifdef IFETCH_STALL_CNT_EN
    check("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
`endif
    $display("[TB] t=%0t rn=%0d ack=%0d cons=%0d len=%0d redir=%0d eip=%h cnt=%0d",
             $time, rn, ack, cons, len, redir, m_eip, sz);
    @(posedge clk2);
    if (!rn) begin
      q.delete();
      m_eip   = RESET_EIP;
      m_block = 1;
      m_stall = 16'd0;
    end else begin
      if (cons && !rdy_e && m_stall != 16'hFFFF) m_stall++;
      if (redir && m_block == 0) m_block = 1;
      else if (m_block > 0) m_block = 0;
      if (redir) begin
        q.delete();
        m_eip = raddr;
      end else begin
        take = cons && rdy_e && (len >= 4'd1) && (len <= 4'd6);
        if (take) begin
          for (int k = 0; k < int'(len); k++) void'(q.pop_front());
          m_eip = m_eip + 32'(len);
        end
        if (req_e && ack) q.push_back(code_byte(fa));
      end
    end
    @(negedge clk2);
  endtask

  initial begin
    logic [31:0] ra;
    reset_n = 1'b0; mem_ack = 1'b0; mem_data = 8'h00; consume = 1'b0;
    consume_len = 4'd1; redirect = 1'b0; redirect_addr = 32'd0;
    repeat (2) @(posedge clk2);
    @(negedge clk2);

    // Reset values, then sequential fill with an ack every cycle.
    cycle(1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 32'd0);
      if (i == 4) begin
        check("first_window", ope, 32'h0001_0203);
        check("first_valid", {31'd0, ope_valid}, 32'd1);
      end
    end
    check("full_no_req", {31'd0, mem_req}, 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 4'd2, 1'b0, 32'd0);
    check("req_restart", {31'd0, mem_req}, 32'd1);
    check("eip_after_2", eip, 32'd2);

    // Wrap of eip and fetch address past 2^32.
    cycle(1'b1, 1'b1, 1'b0, 4'd1, 1'b1, 32'hFFFF_FFFE);
    cycle(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 32'd0);
    check("wrap_eip", eip, 32'h0000_0001);
    check("wrap_fetch", mem_addr, 32'h0000_0002);

    // Randomized traffic, including redirects, bad lengths and mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 32'h0000_0100;
        1:       ra = 32'hFFFF_FFFE;
        2:       ra = 32'hFFFF_FFFC;
        default: ra = $urandom;
      endcase
      cycle(($urandom % 400) != 0, ($urandom % 4) != 0, ($urandom % 3) == 0,
            4'($urandom_range(0, 7)), ($urandom % 30) == 0, ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
